alu_src_sel_pipe: RTL and testbench

Parametrised, registered ALU source-operand selector for the multicycle datapath. It picks one of NUM_SRC operand sources (PC, register A, constants, immediates, etc.) by select code and holds the result in a two-entry skid buffer with a valid/ready handshake, so the ALU may stall without losing operands. It replaces the fixed 32-bit three-way combinational source mux and adds defined out-of-range select behaviour plus a synchronous flush.

---
 rtl/alu_src_sel_pipe.sv | 132 +++++++++++++
 tb/tb_alu_src_sel_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_src_sel_pipe.sv
// Registered ALU source-operand selector with a two-entry skid buffer and valid/ready handshake.
// Optional macro OPSEL_ERR_EN adds a sticky out-of-range select flag (sel_err).
module alu_src_sel_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [WIDTH-1:0]   sel_val;
    logic               accept;
    logic               consume;

`ifdef OPSEL_ERR_EN
    logic               sel_oor;
    logic               sel_err_q, sel_err_d;
`endif

    // Codes that match no channel fall through to zero.
    always_comb begin
        sel_val = '0;
`ifdef OPSEL_ERR_EN
        sel_oor = 1'b1;
`endif
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (sel == SEL_W'(k)) begin
                sel_val = src_flat[k*WIDTH +: WIDTH];
`ifdef OPSEL_ERR_EN
                sel_oor = 1'b0;
`endif
            end
        end
    end

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = out_valid ? head_q : '0;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        head_d  = sel_val;
                    end
                end
                StOne: begin
                    if (accept && !consume) begin
                        state_d = StFull;
                        skid_d  = sel_val;
                    end else if (!accept && consume) begin
                        state_d = StEmpty;
                    end else if (accept && consume) begin
                        head_d  = sel_val;
                    end
                end
                StFull: begin
                    if (consume) begin
                        state_d = StOne;
                        head_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef OPSEL_ERR_EN
    // Flush clears the flag even if the flush cycle also carries a bad select.
    always_comb begin
        sel_err_d = sel_err_q;
        if (flush) begin
            sel_err_d = 1'b0;
        end else if (accept && sel_oor) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_src_sel_pipe.sv
// Scoreboard bench for alu_src_sel_pipe: a 4-source instance under mixed traffic plus a
// 3-source instance for out-of-range selects.
module tb_alu_src_sel_pipe;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [4*W-1:0] src_flat;
    logic [1:0]     sel;
    logic           in_valid, in_ready, flush, out_valid, out_ready, sel_err;
    logic [W-1:0]   out_data;

    logic [3*W-1:0] src3_flat;
    logic [1:0]     sel3;
    logic           in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
    logic [W-1:0]   out_data3;

    alu_src_sel_pipe #(.WIDTH(W), .NUM_SRC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_flat  (src_flat),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    alu_src_sel_pipe #(.WIDTH(W), .NUM_SRC(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_flat  (src3_flat),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .flush     (flush3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
    );

`ifdef OPSEL_ERR_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_sel(input logic [4*W-1:0] s, input logic [1:0] c);
        return s[32*c +: 32];
    endfunction

    // Check outputs against the occupancy model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int sz;
        @(negedge clk);
        sz = exp_q.size();
        check_eq("out_valid", W'(out_valid), W'(sz != 0));
        check_eq("in_ready", W'(in_ready), W'(sz < 2));
        check_eq("out_data", out_data, (sz != 0) ? exp_q[0] : '0);
        check_eq("sel_err4", W'(sel_err), '0);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_ready && sz != 0) void'(exp_q.pop_front());
            if (in_valid && sz < 2) exp_q.push_back(model_sel(src_flat, sel));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        src_flat   = {32'h4, 32'hDEADBEEF, 32'h10, 32'h0};
        sel        = '0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        src3_flat  = {32'h33, 32'h22, 32'h11};
        sel3       = '0;
        in_valid3  = 1'b0;
        flush3     = 1'b0;
        out_ready3 = 1'b0;

        #12;
        check_eq("rst_out_valid", W'(out_valid), '0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_in_ready", W'(in_ready), 32'd1);
        check_eq("rst_sel_err", W'(sel_err3), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic select of channel 2.
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Back-pressure: fill, extra request ignored, then drain.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        cycle();
        sel = 2'd1;
        cycle();
        sel = 2'd2;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        // Streaming with fresh source data every cycle.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel      = 2'(i % 4);
            src_flat = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // Flush while FULL with a request pending, then flush from ONE with an accept.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
        repeat (2) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; sel = 2'd1;
        cycle();
        flush = 1'b1; sel = 2'd2;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) cycle();

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 11) == 0);
            sel       = 2'($urandom_range(0, 3));
            src_flat  = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset while FULL.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
        repeat (2) cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", W'(out_valid), '0);
        check_eq("arst_out_data", out_data, '0);
        check_eq("arst_in_ready", W'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // Out-of-range select on the 3-source instance.
        sel3 = 2'd3; in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("oor_valid", W'(out_valid3), 32'd1);
        check_eq("oor_data", out_data3, '0);
        check_eq("oor_err", W'(sel_err3), W'(ErrExp));
        sel3 = 2'd1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check_eq("oor_full_ready", W'(in_ready3), '0);
        check_eq("oor_head_hold", out_data3, '0);
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("oor_second", out_data3, 32'h22);
        check_eq("oor_ready_back", W'(in_ready3), 32'd1);
        check_eq("oor_err_sticky", W'(sel_err3), W'(ErrExp));
        out_ready3 = 1'b0; flush3 = 1'b1;
        @(posedge clk);
        #1;
        flush3 = 1'b0;
        check_eq("oor_flush_valid", W'(out_valid3), '0);
        check_eq("oor_flush_data", out_data3, '0);
        check_eq("oor_flush_err", W'(sel_err3), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
